// File: rtl/data_mem_responder_if.sv
// Load/store request and response channels between the MEM stage and its data memory.
`timescale 1ns/1ps
interface data_mem_responder_if #(
    parameter int ADDR_W = 5
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [3:0]        req_be;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/data_mem_responder.sv
// Slow data-memory target: accepts one load/store, waits WAIT_CYCLES, then responds.
`timescale 1ns/1ps
module data_mem_responder #(
    parameter int ADDR_W      = 5,
    parameter int WAIT_CYCLES = 2
) (
    input logic                 clk,
    input logic                 rst,
    data_mem_responder_if.slave bus
);
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              req_ready_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rdata_r;

    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [3:0]        acc_be;
    logic [DATA_W-1:0] acc_wdata;
    logic [DATA_W-1:0] cur_word;
    logic [DATA_W-1:0] merged;
    logic              do_access;

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_word,
                                                input logic [DATA_W-1:0] wdata,
                                                input logic [3:0]        be);
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

    // With zero wait states the access happens on the accept edge, so it must
    // see the live request instead of the latched copy.
    always_comb begin
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_be    = be_q;
        acc_wdata = wdata_q;
        if (state == IDLE) begin
            acc_we    = bus.req_we;
            acc_addr  = bus.req_addr;
            acc_be    = bus.req_be;
            acc_wdata = bus.req_wdata;
        end
    end

    assign cur_word  = mem[acc_addr];
    assign merged    = merge(cur_word, acc_wdata, acc_be);
    assign do_access = ((state == IDLE) && bus.req_valid && (WAIT_CYCLES == 0)) ||
                       ((state == WAIT) && (cnt == 4'd0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rdata_r     <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q        <= bus.req_we;
                        addr_q      <= bus.req_addr;
                        be_q        <= bus.req_be;
                        wdata_q     <= bus.req_wdata;
                        req_ready_r <= 1'b0;
                        if (WAIT_CYCLES > 0) begin
                            state <= WAIT;
                            cnt   <= 4'(WAIT_CYCLES - 1);
                        end else begin
                            state       <= RESP;
                            rsp_valid_r <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state       <= RESP;
                        rsp_valid_r <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (do_access) begin
                if (acc_we) mem[acc_addr] <= merged;
                rdata_r <= acc_we ? merged : cur_word;
            end
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rdata_r;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: table-driven transactions on a WAIT_CYCLES=2 instance,
// reset corner cases, and back-to-back traffic on a WAIT_CYCLES=0 instance.
`timescale 1ns/1ps
module tb_data_mem_responder;
    localparam int WAIT = 2;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    logic [31:0] exp_q[$];
    vec_t vecs[10];
    vec_t list0[4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder_if #(.ADDR_W(5)) bus();
    data_mem_responder_if #(.ADDR_W(5)) bus0();

    data_mem_responder #(.ADDR_W(5), .WAIT_CYCLES(WAIT)) dut (.clk(clk), .rst(rst), .bus(bus));
    data_mem_responder #(.ADDR_W(5), .WAIT_CYCLES(0))    dut0(.clk(clk), .rst(rst), .bus(bus0));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pop_exp();
        if (exp_q.size() == 0) return 32'hxxxxxxxx;
        return exp_q.pop_front();
    endfunction

    task automatic drive_req(input vec_t v);
        bus.req_we    = v.we;
        bus.req_addr  = v.addr;
        bus.req_be    = v.be;
        bus.req_wdata = v.wdata;
    endtask

    task automatic txn(input vec_t v, input int stall, input string name);
        int          lat;
        logic [31:0] held;
        vec_t        bogus;
        @(negedge clk);
        drive_req(v);
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b0;
        lat = 0;
        while (!bus.req_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({name, " req_ready"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        exp_q.push_back(v.exp);
        #1 bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'(WAIT + 1));
        check({name, " rdata"}, bus.rsp_rdata, pop_exp());
        held = bus.rsp_rdata;
        if (stall > 0) begin
            bogus = '{1'b1, v.addr, 4'hF, 32'h0BAD0BAD, 32'h0};
            drive_req(bogus);
            bus.req_valid = 1'b1;
            for (int i = 0; i < stall; i++) begin
                @(posedge clk);
                #1;
                check({name, " stall rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
                check({name, " stall rdata"}, bus.rsp_rdata, held);
                check({name, " stall req_ready"}, 32'(bus.req_ready), 32'd0);
            end
            bus.req_valid = 1'b0;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check({name, " rsp_valid drop"}, 32'(bus.rsp_valid), 32'd0);
        check({name, " req_ready back"}, 32'(bus.req_ready), 32'd1);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        int          n_acc;
        int          n_rsp;
        int          last_acc;
        int          lat;
        logic        acc;

        vecs[0] = '{1'b1, 5'd3,  4'hF,    32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1] = '{1'b0, 5'd3,  4'h0,    32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'd3,  4'b0010, 32'h0000AA00, 32'hDEADAAEF};
        vecs[3] = '{1'b0, 5'd3,  4'h0,    32'h0,        32'hDEADAAEF};
        vecs[4] = '{1'b1, 5'd31, 4'hF,    32'h12345678, 32'h12345678};
        vecs[5] = '{1'b0, 5'd0,  4'h0,    32'h0,        32'h00000000};
        vecs[6] = '{1'b0, 5'd31, 4'h0,    32'h0,        32'h12345678};
        vecs[7] = '{1'b1, 5'd5,  4'b0000, 32'hFFFFFFFF, 32'h00000000};
        vecs[8] = '{1'b0, 5'd5,  4'h0,    32'h0,        32'h00000000};
        vecs[9] = '{1'b1, 5'd4,  4'b1001, 32'hAABBCCDD, 32'hAA0000DD};

        list0[0] = '{1'b1, 5'd2, 4'hF,    32'hCAFEF00D, 32'hCAFEF00D};
        list0[1] = '{1'b0, 5'd2, 4'h0,    32'h0,        32'hCAFEF00D};
        list0[2] = '{1'b1, 5'd2, 4'b0100, 32'h00110000, 32'hCA11F00D};
        list0[3] = '{1'b0, 5'd2, 4'h0,    32'h0,        32'hCA11F00D};

        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_addr = '0;
        bus.req_be = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus0.req_valid = 1'b0;
        bus0.req_we = 1'b0;
        bus0.req_addr = '0;
        bus0.req_be = '0;
        bus0.req_wdata = '0;
        bus0.rsp_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("reset req_ready", 32'(bus.req_ready), 32'd1);
        check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset rsp_rdata", bus.rsp_rdata, 32'd0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 10; i++) txn(vecs[i], 0, $sformatf("vec%0d", i));

        // Stalled read: a write offered meanwhile must be ignored.
        txn('{1'b0, 5'd31, 4'h0, 32'h0, 32'h12345678}, 5, "stall_read");
        txn('{1'b0, 5'd31, 4'h0, 32'h0, 32'h12345678}, 0, "after_stall");

        // Reset while a response is pending.
        @(negedge clk);
        drive_req('{1'b1, 5'd9, 4'hF, 32'h11112222, 32'h0});
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        while (!bus.rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("resp_reset reached RESP", 32'(bus.rsp_valid), 32'd1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("resp_reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("resp_reset req_ready", 32'(bus.req_ready), 32'd1);
        check("resp_reset rdata", bus.rsp_rdata, 32'd0);
        @(negedge clk) rst = 1'b0;
        txn('{1'b0, 5'd31, 4'h0, 32'h0, 32'h00000000}, 0, "cleared_31");

        // Reset in the wait window of a write to addr 7.
        @(negedge clk);
        drive_req('{1'b1, 5'd7, 4'hF, 32'h77777777, 32'h0});
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        check("wait_reset in WAIT", 32'(bus.req_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("wait_reset req_ready", 32'(bus.req_ready), 32'd1);
        check("wait_reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("wait_reset no response", 32'(bus.rsp_valid), 32'd0);
        end
        bus.rsp_ready = 1'b0;
        txn('{1'b0, 5'd7, 4'h0, 32'h0, 32'h00000000}, 0, "addr7_after_reset");

        // Zero-wait instance: back-to-back traffic with rsp_ready held high.
        n_acc = 0;
        n_rsp = 0;
        last_acc = -100;
        exp_q.delete();
        @(posedge clk);
        #1;
        bus0.req_we = list0[0].we;
        bus0.req_addr = list0[0].addr;
        bus0.req_be = list0[0].be;
        bus0.req_wdata = list0[0].wdata;
        bus0.req_valid = 1'b1;
        for (int c = 0; c < 30 && n_rsp < 4; c++) begin
            @(negedge clk);
            if (bus0.rsp_valid) begin
                check($sformatf("w0 rdata%0d", n_rsp), bus0.rsp_rdata, pop_exp());
                check($sformatf("w0 latency%0d", n_rsp), 32'(cyc - last_acc + 1), 32'd1);
                n_rsp++;
            end
            acc = bus0.req_valid && bus0.req_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                if (n_acc > 0) check($sformatf("w0 interval%0d", n_acc), 32'(cyc - last_acc), 32'd2);
                last_acc = cyc;
                exp_q.push_back(list0[n_acc].exp);
                n_acc++;
                if (n_acc < 4) begin
                    bus0.req_we = list0[n_acc].we;
                    bus0.req_addr = list0[n_acc].addr;
                    bus0.req_be = list0[n_acc].be;
                    bus0.req_wdata = list0[n_acc].wdata;
                end else begin
                    bus0.req_valid = 1'b0;
                end
            end
        end
        check("w0 responses", 32'(n_rsp), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
